fifo_control_ext: RTL and testbench

- Parametrised successor FIFO controller: manages read/write pointers for an external simple dual-port RAM with configurable read latency.
- Adds over the previous generation: occupancy count, programmable almost-full/almost-empty levels, sticky overflow/underflow errors, synchronous flush, and a read-data-valid strobe aligned to RAM output.
- Sits between a producer/consumer pair and a RAM instance; it never stores data itself.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_control_ext_valid_delay.sv | 38 +++
 rtl/fifo_control_ext.sv | 179 +++++++++++++++++
 tb/tb_fifo_control_ext.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the external-RAM FIFO controller: the depth calculation
// and the parameter legality predicates that the top checks at elaboration.
package fifo_pkg;

    // Number of entries addressed by a pointer of depthLog address bits.
    function automatic int fifo_depth(input int depthLog);
        return 1 << depthLog;
    endfunction

    // Address width must stay within what the pointer arithmetic supports.
    function automatic bit fifo_depth_log_ok(input int depthLog);
        return (depthLog >= 2) && (depthLog <= 16);
    endfunction

    // almost_full must be reachable and must not fire on an empty FIFO.
    function automatic bit fifo_af_level_ok(input int afLevel, input int depthLog);
        return (afLevel >= 1) && (afLevel <= fifo_depth(depthLog));
    endfunction

    // almost_empty must not fire on a completely full FIFO.
    function automatic bit fifo_ae_level_ok(input int aeLevel, input int depthLog);
        return (aeLevel >= 0) && (aeLevel <= fifo_depth(depthLog) - 1);
    endfunction

    // Supported RAM read pipeline depths.
    function automatic bit fifo_rd_lat_ok(input int rdLat);
        return (rdLat >= 1) && (rdLat <= 4);
    endfunction

endpackage

// File: rtl/fifo_control_ext_valid_delay.sv
// Delay line that turns the RAM read strobe into a data-valid strobe lined up
// with the RAM output. A synchronous clear drops reads that are still in flight.
module fifo_valid_delay #(
    parameter int RAM_RD_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic din_i,
    output logic dout_o
);

    logic [RAM_RD_LAT-1:0] pipe_q;
    logic [RAM_RD_LAT-1:0] pipe_d;

    // Shift the strobe one stage per cycle, newest sample entering stage 0.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = din_i;
        for (int i = 1; i < RAM_RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Stage registers; a clear empties every stage so nothing in flight emerges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else if (clr_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout_o = pipe_q[RAM_RD_LAT-1];

endmodule

// File: rtl/fifo_control_ext.sv
// FIFO controller for an external simple dual-port RAM. Keeps the pointers,
// occupancy, level flags and sticky error bits, and drives the RAM ports.
// It holds no payload itself.
module fifo_control_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG  = 8,
    parameter int AF_LEVEL   = (2 ** DEPTH_LOG) - 4,
    parameter int AE_LEVEL   = 4,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_req_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic                 rd_req_i,
    input  logic                 clr_err_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [DEPTH_LOG:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 ram_wr_en_o,
    output logic [DEPTH_LOG-1:0] ram_wr_addr_o,
    output logic [WIDTH-1:0]     ram_wr_data_o,
    output logic                 ram_rd_en_o,
    output logic [DEPTH_LOG-1:0] ram_rd_addr_o,
    output logic                 rd_valid_o
);

    localparam int                 DEPTH   = fifo_depth(DEPTH_LOG);
    localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] AF_C    = (DEPTH_LOG+1)'(AF_LEVEL);
    localparam logic [DEPTH_LOG:0] AE_C    = (DEPTH_LOG+1)'(AE_LEVEL);

    // Reject illegal parameter combinations before anything is built.
    if (!fifo_depth_log_ok(DEPTH_LOG)) begin : gBadDepthLog
        $error("fifo_control_ext: DEPTH_LOG out of range 2..16");
    end
    if (!fifo_af_level_ok(AF_LEVEL, DEPTH_LOG)) begin : gBadAfLevel
        $error("fifo_control_ext: AF_LEVEL out of range 1..DEPTH");
    end
    if (!fifo_ae_level_ok(AE_LEVEL, DEPTH_LOG)) begin : gBadAeLevel
        $error("fifo_control_ext: AE_LEVEL out of range 0..DEPTH-1");
    end
    if (!fifo_rd_lat_ok(RAM_RD_LAT)) begin : gBadRdLat
        $error("fifo_control_ext: RAM_RD_LAT out of range 1..4");
    end

    // Pointers carry one extra wrap bit beyond the RAM address.
    logic [DEPTH_LOG:0]   wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG:0]   rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 almostFull_q, almostFull_d;
    logic                 almostEmpty_q, almostEmpty_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 ramWrEn_q;
    logic [DEPTH_LOG-1:0] ramWrAddr_q;
    logic [WIDTH-1:0]     ramWrData_q;
    logic                 ramRdEn_q;
    logic [DEPTH_LOG-1:0] ramRdAddr_q;

    logic wrAcc;
    logic rdAcc;

    // Accept decisions use the registered flags; flush masks both requests and
    // also keeps them from counting as errors. Flush forces the occupancy and
    // pointers back to zero, and the level flags follow from that zero count,
    // which lands them on their reset values.
    always_comb begin
        wrAcc       = wr_req_i & ~full_q  & ~flush_i;
        rdAcc       = rd_req_i & ~empty_q & ~flush_i;
        wrPtr_d     = wrPtr_q + {{DEPTH_LOG{1'b0}}, wrAcc};
        rdPtr_d     = rdPtr_q + {{DEPTH_LOG{1'b0}}, rdAcc};
        count_d     = count_q + {{DEPTH_LOG{1'b0}}, wrAcc} - {{DEPTH_LOG{1'b0}}, rdAcc};
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end

        full_d        = (count_d == DEPTH_C);
        empty_d       = (count_d == '0);
        almostFull_d  = (count_d >= AF_C);
        almostEmpty_d = (count_d <= AE_C);

        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_req_i & full_q & ~flush_i) begin
            overflow_d = 1'b1;
        end
        if (rd_req_i & empty_q & ~flush_i) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer, occupancy, flag and error state all move on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almostFull_q  <= almostFull_d;
            almostEmpty_q <= almostEmpty_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // RAM port registers: strobes pulse for one cycle per accepted request,
    // addresses and write data hold their last values between strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ramWrEn_q   <= 1'b0;
            ramWrAddr_q <= '0;
            ramWrData_q <= '0;
            ramRdEn_q   <= 1'b0;
            ramRdAddr_q <= '0;
        end else begin
            ramWrEn_q <= wrAcc;
            ramRdEn_q <= rdAcc;
            if (wrAcc) begin
                ramWrAddr_q <= wrPtr_q[DEPTH_LOG-1:0];
                ramWrData_q <= wr_data_i;
            end
            if (rdAcc) begin
                ramRdAddr_q <= rdPtr_q[DEPTH_LOG-1:0];
            end
        end
    end

    fifo_valid_delay #(
        .RAM_RD_LAT (RAM_RD_LAT)
    ) uValidDelay (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .din_i  (ramRdEn_q),
        .dout_o (rd_valid_o)
    );

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = almostFull_q;
    assign almost_empty_o = almostEmpty_q;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;
    assign ram_wr_en_o    = ramWrEn_q;
    assign ram_wr_addr_o  = ramWrAddr_q;
    assign ram_wr_data_o  = ramWrData_q;
    assign ram_rd_en_o    = ramRdEn_q;
    assign ram_rd_addr_o  = ramRdAddr_q;

endmodule

// File: tb/tb_fifo_control_ext.sv
// Directed bench for fifo_control_ext with an 8-entry configuration. A small
// behavioural model predicts occupancy, flags and errors; RAM strobe
// expectations are queued with their due cycle and matched by a monitor.
module tb_fifo_control_ext;

    localparam int DL = 3;
    localparam int WD = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          wr_req_i = 1'b0;
    logic [WD-1:0] wr_data_i = '0;
    logic          rd_req_i = 1'b0;
    logic          clr_err_i = 1'b0;
    logic          full_o, empty_o, almost_full_o, almost_empty_o;
    logic [DL:0]   count_o;
    logic          overflow_o, underflow_o;
    logic          ram_wr_en_o, ram_rd_en_o, rd_valid_o;
    logic [DL-1:0] ram_wr_addr_o, ram_rd_addr_o;
    logic [WD-1:0] ram_wr_data_o;

    fifo_control_ext #(
        .WIDTH      (WD),
        .DEPTH_LOG  (DL),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2),
        .RAM_RD_LAT (1)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .wr_req_i       (wr_req_i),
        .wr_data_i      (wr_data_i),
        .rd_req_i       (rd_req_i),
        .clr_err_i      (clr_err_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .ram_wr_en_o    (ram_wr_en_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_rd_en_o    (ram_rd_en_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .rd_valid_o     (rd_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DL-1:0] addr;
        logic [WD-1:0] data;
        int            due;
    } wrExp_t;

    typedef struct {
        logic [DL-1:0] addr;
        int            due;
    } rdExp_t;

    wrExp_t wrQ[$];
    rdExp_t rdQ[$];
    int     vQ[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state.
    int        mCount = 0;
    logic [DL:0] mWr = '0;
    logic [DL:0] mRd = '0;
    logic      mOv = 1'b0;
    logic      mUn = 1'b0;

    // Cycle number of the most recent rising edge.
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, ".count"}, 32'(count_o), 32'(mCount));
        checkOutput({tag, ".empty"}, 32'(empty_o), 32'(mCount == 0));
        checkOutput({tag, ".full"}, 32'(full_o), 32'(mCount == 8));
        checkOutput({tag, ".almostFull"}, 32'(almost_full_o), 32'(mCount >= 6));
        checkOutput({tag, ".almostEmpty"}, 32'(almost_empty_o), 32'(mCount <= 2));
        checkOutput({tag, ".overflow"}, 32'(overflow_o), 32'(mOv));
        checkOutput({tag, ".underflow"}, 32'(underflow_o), 32'(mUn));
    endtask

    // Drive one cycle of requests at a falling edge, record what the model
    // expects, and return at the next falling edge with inputs idle.
    task automatic applyStimulus(input logic wr, input logic [WD-1:0] data, input logic rd,
                                 input logic fl, input logic clr);
        logic   wA, rA;
        wrExp_t we;
        rdExp_t re;
        int     keep[$];
        wr_req_i  = wr;
        wr_data_i = data;
        rd_req_i  = rd;
        flush_i   = fl;
        clr_err_i = clr;
        wA = !fl && wr && (mCount != 8);
        rA = !fl && rd && (mCount != 0);
        if (clr) begin
            mOv = 1'b0;
            mUn = 1'b0;
        end
        if (!fl && wr && (mCount == 8)) mOv = 1'b1;
        if (!fl && rd && (mCount == 0)) mUn = 1'b1;
        if (wA) begin
            we.addr = mWr[DL-1:0];
            we.data = data;
            we.due  = cyc + 1;
            wrQ.push_back(we);
            mWr = mWr + 1'b1;
            mCount++;
        end
        if (rA) begin
            re.addr = mRd[DL-1:0];
            re.due  = cyc + 1;
            rdQ.push_back(re);
            vQ.push_back(cyc + 2);
            mRd = mRd + 1'b1;
            mCount--;
        end
        if (fl) begin
            mCount = 0;
            mWr = '0;
            mRd = '0;
            foreach (vQ[i]) if (vQ[i] <= cyc) keep.push_back(vQ[i]);
            vQ = keep;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        wr_req_i  = 1'b0;
        rd_req_i  = 1'b0;
        flush_i   = 1'b0;
        clr_err_i = 1'b0;
    endtask

    // Match every RAM strobe and rd_valid pulse against its queued expectation.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (ram_wr_en_o) begin
                if (wrQ.size() > 0 && wrQ[0].due == cyc) begin
                    wrExp_t e;
                    e = wrQ.pop_front();
                    checkOutput("ramWrAddr", 32'(ram_wr_addr_o), 32'(e.addr));
                    checkOutput("ramWrData", 32'(ram_wr_data_o), 32'(e.data));
                end else begin
                    checkOutput("ramWrEnUnexpected", 32'(ram_wr_en_o), 32'd0);
                end
            end else if (wrQ.size() > 0 && wrQ[0].due <= cyc) begin
                void'(wrQ.pop_front());
                checkOutput("ramWrEnMissing", 32'(ram_wr_en_o), 32'd1);
            end
            if (ram_rd_en_o) begin
                if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
                    rdExp_t e;
                    e = rdQ.pop_front();
                    checkOutput("ramRdAddr", 32'(ram_rd_addr_o), 32'(e.addr));
                end else begin
                    checkOutput("ramRdEnUnexpected", 32'(ram_rd_en_o), 32'd0);
                end
            end else if (rdQ.size() > 0 && rdQ[0].due <= cyc) begin
                void'(rdQ.pop_front());
                checkOutput("ramRdEnMissing", 32'(ram_rd_en_o), 32'd1);
            end
            if (rd_valid_o) begin
                if (vQ.size() > 0 && vQ[0] == cyc) begin
                    void'(vQ.pop_front());
                    checkOutput("rdValidTiming", 32'(rd_valid_o), 32'd1);
                end else begin
                    checkOutput("rdValidUnexpected", 32'(rd_valid_o), 32'd0);
                end
            end else if (vQ.size() > 0 && vQ[0] <= cyc) begin
                void'(vQ.pop_front());
                checkOutput("rdValidMissing", 32'(rd_valid_o), 32'd1);
            end
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset and check every output's reset value.
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        checkFlags("reset");
        checkOutput("reset.ramWrEn", 32'(ram_wr_en_o), 32'd0);
        checkOutput("reset.ramWrAddr", 32'(ram_wr_addr_o), 32'd0);
        checkOutput("reset.ramWrData", 32'(ram_wr_data_o), 32'd0);
        checkOutput("reset.ramRdEn", 32'(ram_rd_en_o), 32'd0);
        checkOutput("reset.ramRdAddr", 32'(ram_rd_addr_o), 32'd0);
        checkOutput("reset.rdValid", 32'(rd_valid_o), 32'd0);

        // Fill from empty.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, WD'(i + 1), 1'b0, 1'b0, 1'b0);
            checkFlags($sformatf("fill%0d", i + 1));
        end
        checkOutput("fill.fullConst", 32'(full_o), 32'd1);

        // Write while full, then clear the error.
        applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        checkFlags("overflow");
        checkOutput("overflow.countConst", 32'(count_o), 32'd8);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkFlags("clrOverflow");

        // Drain, then write across the wrap point.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkFlags($sformatf("drain%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, WD'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        end
        checkFlags("wrap");
        checkOutput("wrap.countConst", 32'(count_o), 32'd4);

        // Simultaneous requests at mid occupancy.
        applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, WD'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
            checkFlags($sformatf("both%0d", i));
        end

        // Simultaneous requests while full.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, WD'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        checkFlags("refill");
        applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 1'b0);
        checkFlags("bothFull");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Simultaneous requests while empty, then set-beats-clear on underflow.
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkFlags("drained");
        applyStimulus(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
        checkFlags("bothEmpty");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checkFlags("setWins");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkFlags("clrUnderflow");

        // Flush right after a read, with overflow left set.
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, WD'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkFlags("preFlush");
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        checkFlags("flush");
        checkOutput("flush.rdValid", 32'(rd_valid_o), 32'd0);
        checkOutput("flush.ramRdEn", 32'(ram_rd_en_o), 32'd0);
        checkOutput("flush.overflowConst", 32'(overflow_o), 32'd1);
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        checkOutput("postFlush.rdValid", 32'(rd_valid_o), 32'd0);
        checkFlags("postFlush");

        // Asynchronous reset during a write burst.
        applyStimulus(1'b1, 8'h67, 1'b0, 1'b0, 1'b0);
        wr_req_i  = 1'b1;
        wr_data_i = 8'h68;
        #2;
        rst_i = 1'b1;
        wrQ.delete();
        rdQ.delete();
        vQ.delete();
        mCount = 0;
        mWr = '0;
        mRd = '0;
        mOv = 1'b0;
        mUn = 1'b0;
        #1;
        checkFlags("asyncReset");
        checkOutput("asyncReset.ramWrEn", 32'(ram_wr_en_o), 32'd0);
        checkOutput("asyncReset.ramWrAddr", 32'(ram_wr_addr_o), 32'd0);
        checkOutput("asyncReset.ramWrData", 32'(ram_wr_data_o), 32'd0);
        checkOutput("asyncReset.rdValid", 32'(rd_valid_o), 32'd0);
        wr_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        // Operation resumes from address zero.
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        checkFlags("afterReset");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("scoreboardDrained", 32'(wrQ.size() + rdQ.size() + vQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
